// File: rtl/kfmmc_spi_target_pkg.sv
// KFMMC SPI target: shared types, frame constants and CRC7 helper.
// Used by kfmmc_spi_target and kfmmc_crc7 (KFMMC_SPI_TARGET_CRC7_EN).
package kfmmc_spi_target_pkg;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_COLLECT
  } frame_state_t;

  localparam logic [1:0] CMD_START_BITS = 2'b01;
  localparam int unsigned CMD_FRAME_BYTES = 6;
  localparam logic [2:0] CMD_LAST_BYTE = 3'(CMD_FRAME_BYTES - 1);
  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_next(
    input logic [6:0] crc,
    input logic [7:0] data
  );
    logic [6:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/kfmmc_spi_target_if.sv
// KFMMC SPI link wires: initiator (master) and card-side target (slave).
interface kfmmc_spi_target_if;
  logic spi_cs_n;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_cs_n,
    output spi_clk,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_cs_n,
    input  spi_clk,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/kfmmc_crc7.sv
// Byte-serial CRC7 (x^7+x^3+1, init 0) over MMC command bytes.
module kfmmc_crc7
  import kfmmc_spi_target_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [6:0] crc
);

  // clear with byte_valid restarts the CRC on that byte
  always_ff @(posedge clock) begin
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= byte_valid ? crc7_next('0, byte_in) : '0;
    end else if (byte_valid) begin
      crc <= crc7_next(crc, byte_in);
    end
  end

endmodule

// File: rtl/kfmmc_spi_target.sv
// KFMMC SPI mode-0 target with 6-byte command frame capture.
// Define KFMMC_SPI_TARGET_CRC7_EN to check the command CRC7.
module kfmmc_spi_target
  import kfmmc_spi_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  kfmmc_spi_target_if.slave spi,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  output logic        cmd_crc_error
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic clk_d;
  logic sel_d;
  logic clk_s;
  logic mosi_s;
  logic selected;
  logic rise;
  logic fall;
  logic sel_start;
  logic load_pt;
  logic load_pend;
  logic byte_done;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] new_byte;

  frame_state_t frame_state;
  frame_state_t frame_state_n;
  logic [2:0] fbyte;
  logic [2:0] fbyte_n;
  logic frame_start;
  logic frame_end;
  logic [5:0] idx_acc;
  logic [31:0] arg_acc;
  logic crc_err;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign selected  = ~cs_sync[SYNC_STAGES-1];
  assign rise      = selected & clk_s & ~clk_d;
  assign fall      = selected & ~clk_s & clk_d;
  assign sel_start = selected & ~sel_d;
  assign load_pt   = sel_start | (fall & load_pend);
  assign byte_done = rise & (bit_cnt == 3'd7);
  assign new_byte  = {rx_shift[6:0], mosi_s};

  assign tx_ready    = ~reset & load_pt & tx_valid;
  assign tx_underrun = ~reset & load_pt & ~tx_valid;
  assign spi.spi_miso = selected ? tx_shift[7] : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      clk_d     <= 1'b0;
      sel_d     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
      clk_d     <= clk_s;
      sel_d     <= selected;
    end
  end

  // load_pend marks the falling edge after a full byte as a load point
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      load_pend <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!selected) begin
        bit_cnt   <= '0;
        rx_shift  <= '0;
        tx_shift  <= '0;
        load_pend <= 1'b0;
      end else begin
        if (load_pt) begin
          tx_shift  <= tx_valid ? tx_data : FILL_BYTE;
          load_pend <= 1'b0;
        end else if (fall) begin
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
        if (rise) begin
          rx_shift <= new_byte;
          if (bit_cnt == 3'd7) begin
            bit_cnt   <= '0;
            rx_data   <= new_byte;
            rx_valid  <= 1'b1;
            load_pend <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_state <= FRAME_IDLE;
      fbyte       <= '0;
    end else begin
      frame_state <= frame_state_n;
      fbyte       <= fbyte_n;
    end
  end

  always_comb begin
    frame_state_n = frame_state;
    fbyte_n       = fbyte;
    frame_start   = 1'b0;
    frame_end     = 1'b0;
    unique case (frame_state)
      FRAME_IDLE: begin
        if (byte_done && new_byte[7:6] == CMD_START_BITS) begin
          frame_state_n = FRAME_COLLECT;
          fbyte_n       = 3'd1;
          frame_start   = 1'b1;
        end
      end
      FRAME_COLLECT: begin
        if (byte_done) begin
          if (fbyte == CMD_LAST_BYTE) begin
            frame_state_n = FRAME_IDLE;
            fbyte_n       = '0;
            frame_end     = 1'b1;
          end else begin
            fbyte_n = fbyte + 3'd1;
          end
        end
      end
      default: frame_state_n = FRAME_IDLE;
    endcase
    if (!selected) begin
      frame_state_n = FRAME_IDLE;
      fbyte_n       = '0;
      frame_start   = 1'b0;
      frame_end     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_acc       <= '0;
      arg_acc       <= '0;
      cmd_valid     <= 1'b0;
      cmd_index     <= '0;
      cmd_arg       <= '0;
      cmd_crc       <= '0;
      cmd_crc_error <= 1'b0;
    end else begin
      cmd_valid <= frame_end;
      if (frame_start) begin
        idx_acc <= new_byte[5:0];
        arg_acc <= '0;
      end else if (frame_state == FRAME_COLLECT && byte_done && !frame_end) begin
        arg_acc <= {arg_acc[23:0], new_byte};
      end
      if (frame_end) begin
        cmd_index     <= idx_acc;
        cmd_arg       <= arg_acc;
        cmd_crc       <= new_byte[7:1];
        cmd_crc_error <= crc_err;
      end
    end
  end

`ifdef KFMMC_SPI_TARGET_CRC7_EN
  logic [6:0] crc_calc;
  logic crc_feed;

  // bytes 0-4 are covered; byte 5 carries the CRC itself
  assign crc_feed = frame_start |
    (frame_state == FRAME_COLLECT & byte_done & ~frame_end);

  kfmmc_crc7 u_crc7 (
    .clock      (clock),
    .reset      (reset),
    .clear      (frame_start | ~selected),
    .byte_in    (new_byte),
    .byte_valid (crc_feed),
    .crc        (crc_calc)
  );

  assign crc_err = (crc_calc != new_byte[7:1]) | ~new_byte[0];
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_kfmmc_spi_target.sv
// Directed bench for kfmmc_spi_target: byte exchange, underrun, frames.
module tb_kfmmc_spi_target;

`ifdef KFMMC_SPI_TARGET_CRC7_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam int HALF = 8;

  logic clock = 1'b0;
  logic reset;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_underrun;
  logic [7:0] rx_data;
  logic rx_valid;
  logic cmd_valid;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0] cmd_crc;
  logic cmd_crc_error;

  kfmmc_spi_target_if bus ();

  kfmmc_spi_target dut (
    .clock         (clock),
    .reset         (reset),
    .spi           (bus.slave),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_underrun   (tx_underrun),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .cmd_valid     (cmd_valid),
    .cmd_index     (cmd_index),
    .cmd_arg       (cmd_arg),
    .cmd_crc       (cmd_crc),
    .cmd_crc_error (cmd_crc_error)
  );

  always #5 clock = ~clock;

  // tx source: FIFO of offered bytes, popped after each consume
  logic [7:0] tx_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign tx_valid = (rd_ptr != wr_ptr);
  assign tx_data  = tx_mem[rd_ptr[5:0]];

  always begin
    @(negedge clock);
    if (tx_ready) begin
      @(posedge clock);
      #1;
      rd_ptr++;
    end
  end

  int n_rx = 0, n_rdy = 0, n_und = 0, n_cmd = 0;
  logic [7:0] last_rx = '0;
  always @(negedge clock) begin
    if (rx_valid) begin
      n_rx++;
      last_rx = rx_data;
    end
    if (tx_ready) n_rdy++;
    if (tx_underrun) n_und++;
    if (cmd_valid) n_cmd++;
  end

  int s_rx, s_rdy, s_und, s_cmd;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap();
    s_rx = n_rx;
    s_rdy = n_rdy;
    s_und = n_und;
    s_cmd = n_cmd;
  endtask

  task automatic push(input logic [7:0] d);
    tx_mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic sel();
    bus.spi_cs_n = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic desel();
    clk_wait(HALF);
    bus.spi_cs_n = 1'b1;
    clk_wait(10);
  endtask

  task automatic spi_byte(input logic [7:0] mo, input int nbits,
                          input bit end_low, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = mo[7-i];
      clk_wait(HALF);
      mi = {mi[6:0], bus.spi_miso};
      bus.spi_clk = 1'b1;
      clk_wait(HALF);
      if (i < nbits - 1 || end_low) bus.spi_clk = 1'b0;
    end
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    logic [7:0] mi;
    foreach (seq[i]) spi_byte(seq[i], 8, 1'b1, mi);
  endtask

  typedef struct {
    logic [7:0] mosi;
    bit         offer;
    logic [7:0] tx;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [7:0] mi, m0, m1;
    logic [7:0] q[$];

    vt[0] = '{8'h3C, 1'b1, 8'hA5, 8'hA5, 8'h3C};
    vt[1] = '{8'hC3, 1'b1, 8'h5A, 8'h5A, 8'hC3};
    vt[2] = '{8'h00, 1'b0, 8'h00, 8'hFF, 8'h00};
    vt[3] = '{8'hFF, 1'b1, 8'h00, 8'h00, 8'hFF};
    vt[4] = '{8'h81, 1'b1, 8'h7E, 8'h7E, 8'h81};

    reset = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b1;
    clk_wait(4);
    snap();
    for (int i = 0; i < 3; i++) begin
      bus.spi_clk = 1'b1;
      clk_wait(HALF);
      bus.spi_clk = 1'b0;
      clk_wait(HALF);
    end
    chk("rst_miso", bus.spi_miso, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_cmd_index", cmd_index, 0);
    chk("rst_cmd_arg", cmd_arg, 0);
    chk("rst_cmd_crc", cmd_crc, 0);
    chk("rst_crc_err", cmd_crc_error, 0);
    reset = 1'b0;
    clk_wait(4);
    for (int i = 0; i < 4; i++) begin
      bus.spi_clk = 1'b1;
      clk_wait(HALF);
      bus.spi_clk = 1'b0;
      clk_wait(HALF);
    end
    chk("idle_miso", bus.spi_miso, 1);
    chk("idle_rx_valid", n_rx - s_rx, 0);
    chk("idle_tx_ready", n_rdy - s_rdy, 0);
    chk("idle_underrun", n_und - s_und, 0);

    for (int v = 0; v < 5; v++) begin
      snap();
      if (vt[v].offer) push(vt[v].tx);
      sel();
      spi_byte(vt[v].mosi, 8, 1'b1, mi);
      desel();
      chk($sformatf("v%0d_miso", v), mi, vt[v].exp_miso);
      chk($sformatf("v%0d_rx", v), last_rx, vt[v].exp_rx);
      chk($sformatf("v%0d_rx_data", v), rx_data, vt[v].exp_rx);
      chk($sformatf("v%0d_n_rx", v), n_rx - s_rx, 1);
      chk($sformatf("v%0d_n_ready", v), n_rdy - s_rdy, vt[v].offer ? 1 : 0);
      chk($sformatf("v%0d_n_under", v), n_und - s_und, vt[v].offer ? 1 : 2);
      chk($sformatf("v%0d_n_cmd", v), n_cmd - s_cmd, 0);
    end

    // two starved bytes, then a byte offered before the final fall
    snap();
    sel();
    spi_byte(8'h12, 8, 1'b1, m0);
    spi_byte(8'h34, 8, 1'b0, m1);
    chk("und_two", n_und - s_und, 2);
    push(8'h77);
    bus.spi_clk = 1'b0;
    desel();
    chk("und_miso0", m0, 8'hFF);
    chk("und_miso1", m1, 8'hFF);
    chk("und_ready", n_rdy - s_rdy, 1);
    chk("und_total", n_und - s_und, 2);
    chk("und_rx", last_rx, 8'h34);

    snap();
    sel();
    q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    send_seq(q);
    desel();
    chk("cmd0_n_cmd", n_cmd - s_cmd, 1);
    chk("cmd0_n_rx", n_rx - s_rx, 7);
    chk("cmd0_index", cmd_index, 0);
    chk("cmd0_arg", cmd_arg, 0);
    chk("cmd0_crc", cmd_crc, 7'h4A);
    chk("cmd0_crc_err", cmd_crc_error, 0);

    snap();
    sel();
    q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h94};
    send_seq(q);
    desel();
    chk("bad_n_cmd", n_cmd - s_cmd, 1);
    chk("bad_crc", cmd_crc, 7'h4A);
    chk("bad_crc_err", cmd_crc_error, CRC_ON);

    snap();
    sel();
    q = '{8'h40, 8'h00, 8'h00};
    send_seq(q);
    spi_byte(8'hA0, 4, 1'b1, mi);
    desel();
    chk("abort_n_rx", n_rx - s_rx, 3);
    chk("abort_n_cmd", n_cmd - s_cmd, 0);

    snap();
    sel();
    q = '{8'h51, 8'h80, 8'h00, 8'h02, 8'h01, 8'h5D};
    send_seq(q);
    desel();
    chk("cmd17_n_cmd", n_cmd - s_cmd, 1);
    chk("cmd17_n_rx", n_rx - s_rx, 6);
    chk("cmd17_index", cmd_index, 6'h11);
    chk("cmd17_arg", cmd_arg, 32'h8000_0201);
    chk("cmd17_crc", cmd_crc, 7'h2E);
    chk("cmd17_crc_err", cmd_crc_error, 0);

    snap();
    sel();
    q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
          8'h51, 8'h80, 8'h00, 8'h02, 8'h01, 8'h5D};
    send_seq(q);
    desel();
    chk("b2b_n_cmd", n_cmd - s_cmd, 2);
    chk("b2b_index", cmd_index, 6'h11);
    chk("b2b_arg", cmd_arg, 32'h8000_0201);

    // reset in the middle of a byte
    sel();
    spi_byte(8'h40, 4, 1'b1, mi);
    reset = 1'b1;
    clk_wait(3);
    chk("mid_rst_miso", bus.spi_miso, 1);
    chk("mid_rst_index", cmd_index, 0);
    chk("mid_rst_arg", cmd_arg, 0);
    chk("mid_rst_rx", rx_data, 0);
    bus.spi_cs_n = 1'b1;
    reset = 1'b0;
    clk_wait(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
